// File: rtl/ftdi_fifo_arbiter_if.sv
// rtl/ftdi_fifo_arbiter_if.sv - FTDI strobes and local FIFO handshakes of the FT60x bus arbiter
interface ftdi_fifo_arbiter_if;
  logic        iTXE_N;
  logic        iRXF_N;
  logic        oOE_N;
  logic        oRD_N;
  logic        oWR_N;
  logic [1:0]  oGPIO;
  logic [31:0] iTX_DATA;
  logic        iTX_EMPTY;
  logic        oTX_RD;
  logic [31:0] oRX_DATA;
  logic        oRX_WR;
  logic        iRX_AFULL;
  logic        oBUSY;

  modport master (
    input  iTXE_N, iRXF_N, iTX_DATA, iTX_EMPTY, iRX_AFULL,
    output oOE_N, oRD_N, oWR_N, oGPIO, oTX_RD, oRX_DATA, oRX_WR, oBUSY
  );

  modport slave (
    output iTXE_N, iRXF_N, iTX_DATA, iTX_EMPTY, iRX_AFULL,
    input  oOE_N, oRD_N, oWR_N, oGPIO, oTX_RD, oRX_DATA, oRX_WR, oBUSY
  );
endinterface

// File: rtl/ftdi_fifo_arbiter.sv
// rtl/ftdi_fifo_arbiter.sv - FT60x 245 sync FIFO master, round-robin RX/TX burst arbiter
module ftdi_fifo_arbiter #(
  parameter int BUF_SIZE = 256,
  parameter int CNT_W    = 10
) (
  input  logic                 iCLK,
  input  logic                 iRESET,
  inout  wire  [31:0]          ioDATA,
  inout  wire  [3:0]           ioBE,
  ftdi_fifo_arbiter_if.master  ftdi
);

  typedef enum logic [2:0] {
    IDLE,
    RD_OE,
    RD_DATA,
    RD_END,
    TURN,
    WR_DATA,
    WR_END
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUF_SIZE);

  state_t           state;
  logic [CNT_W-1:0] wordCnt;
  logic             lastGrantTx;

  wire rxReq   = ~ftdi.iRXF_N & ~ftdi.iRX_AFULL;
  wire txReq   = ~ftdi.iTXE_N & ~ftdi.iTX_EMPTY;
  wire grantRx = rxReq & (~txReq | lastGrantTx);
  wire grantTx = txReq & (~rxReq | ~lastGrantTx);

  wire rdXfer = ~ftdi.oRD_N & ~ftdi.iRXF_N & (|ioBE);
  wire wrPop  = ~ftdi.oWR_N & ~ftdi.iTXE_N & ~ftdi.iTX_EMPTY;

  wire [CNT_W-1:0] cntNext = (wordCnt == CNT_MAX) ? wordCnt : wordCnt + CNT_W'(1);

  // The bus is ours only while WR_DATA is the registered state.
  wire driveBus = (state == WR_DATA);
  assign ioDATA = driveBus ? ftdi.iTX_DATA : {32{1'bz}};
  assign ioBE   = driveBus ? (ftdi.iTX_EMPTY ? 4'h0 : 4'hF) : {4{1'bz}};

  assign ftdi.oTX_RD = wrPop;
  assign ftdi.oGPIO  = 2'b00;

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state         <= IDLE;
      wordCnt       <= '0;
      lastGrantTx   <= 1'b1;
      ftdi.oOE_N    <= 1'b1;
      ftdi.oRD_N    <= 1'b1;
      ftdi.oWR_N    <= 1'b1;
      ftdi.oRX_DATA <= '0;
      ftdi.oRX_WR   <= 1'b0;
      ftdi.oBUSY    <= 1'b0;
    end else begin
      ftdi.oRX_WR <= 1'b0;
      case (state)
        IDLE: begin
          if (grantRx) begin
            state       <= RD_OE;
            ftdi.oOE_N  <= 1'b0;
            ftdi.oBUSY  <= 1'b1;
            wordCnt     <= '0;
            lastGrantTx <= 1'b0;
          end else if (grantTx) begin
            state       <= WR_DATA;
            ftdi.oWR_N  <= 1'b0;
            ftdi.oBUSY  <= 1'b1;
            wordCnt     <= '0;
            lastGrantTx <= 1'b1;
          end
        end
        RD_OE: begin
          state      <= RD_DATA;
          ftdi.oRD_N <= 1'b0;
        end
        RD_DATA: begin
          if (rdXfer) begin
            ftdi.oRX_DATA <= ioDATA;
            ftdi.oRX_WR   <= 1'b1;
            wordCnt       <= cntNext;
          end
          if (ftdi.iRXF_N || ftdi.iRX_AFULL || (rdXfer && cntNext == CNT_MAX)) begin
            state      <= RD_END;
            ftdi.oRD_N <= 1'b1;
            ftdi.oOE_N <= 1'b1;
          end
        end
        RD_END: begin
          state <= TURN;
        end
        TURN: begin
          state      <= IDLE;
          ftdi.oBUSY <= 1'b0;
        end
        WR_DATA: begin
          if (wrPop) begin
            wordCnt <= cntNext;
          end
          if (ftdi.iTXE_N || ftdi.iTX_EMPTY || (wrPop && cntNext == CNT_MAX)) begin
            state      <= WR_END;
            ftdi.oWR_N <= 1'b1;
          end
        end
        WR_END: begin
          state      <= IDLE;
          ftdi.oBUSY <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          ftdi.oOE_N <= 1'b1;
          ftdi.oRD_N <= 1'b1;
          ftdi.oWR_N <= 1'b1;
          ftdi.oBUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule
